// File: rtl/osc_capture_buffer.sv
// osc_capture_buffer: double-buffered, trigger-aligned ADC sample capture.
// One bank is written by the capture FSM while the other bank is read by the
// display by column index. Banks swap on a vsync rising edge once a record
// is complete.
// Optional feature: define OSC_AUTO_TRIG_EN to force a trigger after TIMEOUT
// accepted samples spent waiting in ARM.
module osc_capture_buffer #(
  parameter int DW        = 8,
  parameter int AW        = 10,
  parameter int PRE_DEPTH = 512,
  parameter int TIMEOUT   = 65535
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          run,
  input  logic          ad_valid,
  input  logic [DW-1:0] ad_data,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  input  logic          i_vs,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          disp_valid,
  output logic          triggered,
  output logic [7:0]    frame_cnt
);

  localparam int DEPTH  = 1 << AW;
  localparam int POST_N = DEPTH - PRE_DEPTH - 1;

  if (PRE_DEPTH < 1 || PRE_DEPTH >= DEPTH || TIMEOUT < 1) begin : g_bad_cfg
    $error("osc_capture_buffer: illegal PRE_DEPTH/AW/TIMEOUT combination");
  end

  typedef enum logic [2:0] {IDLE, PRE, ARM, POST, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;            // pre-trigger count in PRE, post count in POST
  logic [AW-1:0] start_ptr_q, start_ptr_d;
  logic [AW-1:0] disp_start_q, disp_start_d;
  logic          cap_bank_q, cap_bank_d;
  logic          disp_valid_q, disp_valid_d;
  logic          trig_q, trig_d;
  logic [7:0]    frame_q, frame_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic          vs_prev_q, vs_prev_d;
  logic          vs_rise_q, vs_rise_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

`ifdef OSC_AUTO_TRIG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  logic [DW-1:0] mem [0:2*DEPTH-1];
  logic          we;
  logic          fire;
  logic          edge_hit;
  logic [AW-1:0] rd_idx;

  // Level crossing relative to the previously accepted sample
  always_comb begin
    edge_hit = 1'b0;
    if (prev_vld_q) begin
      if (trig_edge) edge_hit = (prev_q > trig_level) && (trig_level >= ad_data);
      else           edge_hit = (prev_q < trig_level) && (trig_level <= ad_data);
    end
  end

  // Capture FSM next state, pointer bookkeeping and bank swap
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    start_ptr_d  = start_ptr_q;
    disp_start_d = disp_start_q;
    cap_bank_d   = cap_bank_q;
    disp_valid_d = disp_valid_q;
    frame_d      = frame_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    trig_d       = 1'b0;
    we           = 1'b0;
    fire         = 1'b0;
    vs_prev_d    = i_vs;
    // only an edge seen while already DONE may swap; one landing on the
    // final POST sample waits for the next frame
    vs_rise_d    = i_vs & ~vs_prev_q & (state_q == DONE);
`ifdef OSC_AUTO_TRIG_EN
    to_d         = to_q;
`endif

    if (state_q != IDLE && ad_valid) begin
      prev_d     = ad_data;
      prev_vld_d = 1'b1;
    end

    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          prev_vld_d = 1'b0;
          state_d    = PRE;
          cnt_d      = '0;
          wr_ptr_d   = '0;
        end
        PRE: begin
`ifdef OSC_AUTO_TRIG_EN
          to_d = '0;
`endif
          if (ad_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + AW'(1);
            if (cnt_q == AW'(PRE_DEPTH - 1)) state_d = ARM;
          end
        end
        ARM: begin
          if (ad_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            fire     = edge_hit;
`ifdef OSC_AUTO_TRIG_EN
            if (to_q == TW'(TIMEOUT - 1)) fire = 1'b1;
            to_d = to_q + TW'(1);
`endif
            if (fire) begin
              trig_d      = 1'b1;
              start_ptr_d = wr_ptr_q - AW'(PRE_DEPTH);
              cnt_d       = '0;
              state_d     = (POST_N == 0) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (ad_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + AW'(1);
            if (cnt_q == AW'(POST_N - 1)) state_d = DONE;
          end
        end
        DONE: begin
          if (vs_rise_q) begin
            cap_bank_d   = ~cap_bank_q;
            disp_start_d = start_ptr_q;
            disp_valid_d = 1'b1;
            frame_d      = frame_q + 8'd1;
            state_d      = PRE;
            cnt_d        = '0;
            wr_ptr_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Display read path: index is relative to the oldest pre-trigger sample
  always_comb begin
    rd_idx    = disp_start_q + rd_addr;
    rd_data_d = '0;
    if (disp_valid_q) rd_data_d = mem[{~cap_bank_q, rd_idx}];
  end

  // Control state registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      start_ptr_q  <= '0;
      disp_start_q <= '0;
      cap_bank_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      trig_q       <= 1'b0;
      frame_q      <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      vs_prev_q    <= 1'b0;
      vs_rise_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      start_ptr_q  <= start_ptr_d;
      disp_start_q <= disp_start_d;
      cap_bank_q   <= cap_bank_d;
      disp_valid_q <= disp_valid_d;
      trig_q       <= trig_d;
      frame_q      <= frame_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      vs_prev_q    <= vs_prev_d;
      vs_rise_q    <= vs_rise_d;
      rd_data_q    <= rd_data_d;
    end
  end

`ifdef OSC_AUTO_TRIG_EN
  // Auto-trigger timeout counter
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`endif

  // Sample RAM, both banks; contents survive reset
  always_ff @(posedge pclk) begin
    if (we) mem[{cap_bank_q, wr_ptr_q}] <= ad_data;
  end

  assign rd_data    = rd_data_q;
  assign disp_valid = disp_valid_q;
  assign triggered  = trig_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_osc_capture_buffer.sv
// Bench for osc_capture_buffer: ramp/random records checked against a
// sample-stream model, plus swap timing, run drop, reset and no-trigger cases.
module tb_osc_capture_buffer;
  localparam int AW = 10, DEPTH = 1024, PRE = 512, POST_N = DEPTH - PRE - 1;
  localparam int MAXS = 4700;

  logic pclk = 0, rst = 0, run = 0, ad_valid = 0, trig_edge = 0, i_vs = 0;
  logic [7:0] ad_data = 0, trig_level = 0;
  logic [AW-1:0] rd_addr = 0;
  logic [7:0] rd_data, frame_cnt;
  logic disp_valid, triggered;

  int vectors = 0, miscompares = 0, trig_seen = 0;
  int rec_s [0:MAXS-1];
  int exp_disp [0:DEPTH-1];
  int pend [0:DEPTH-1];
  int frame_exp = 0, rec_k = -1;
  bit dv_exp = 0;

  typedef struct { int rec; int addr; int exp; } vec_t;
  vec_t tbl [8];

  osc_capture_buffer dut (
    .pclk(pclk), .rst(rst), .run(run), .ad_valid(ad_valid), .ad_data(ad_data),
    .trig_level(trig_level), .trig_edge(trig_edge), .i_vs(i_vs), .rd_addr(rd_addr),
    .rd_data(rd_data), .disp_valid(disp_valid), .triggered(triggered), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;
  always @(negedge pclk) if (triggered === 1'b1) trig_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge pclk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int gen(input int mode, input int i);
    case (mode)
      0: return i % 256;
      1: return 255 - (i % 256);
      2: return int'($urandom_range(0, 255));
      default: return 50;
    endcase
  endfunction

  function automatic bit is_trig(input bit e, input int lvl, input int p, input int d);
    if (e) return (p > lvl) && (lvl >= d);
    return (p < lvl) && (lvl <= d);
  endfunction

  task automatic send(input int d, input bit vs);
    ad_valid = 1; ad_data = d[7:0]; i_vs = vs;
    tick;
    ad_valid = 0; i_vs = 0;
  endtask

  task automatic gap;
    repeat ($urandom_range(0, 1)) tick;
  endtask

  // Feeds one record's sample stream; stop_post >= 0 stops that many samples after the trigger
  task automatic run_record(input int mode, input bit e, input int lvl, input int stop_post);
    int i, d, t0;
    bit hit, last, ok;
    trig_edge = e; trig_level = lvl[7:0];
    rec_k = -1; ok = 0; t0 = trig_seen;
    for (i = 0; i < MAXS; i++) begin
      d = gen(mode, i);
      rec_s[i] = d;
      hit  = (rec_k < 0) && (i >= PRE) && is_trig(e, lvl, rec_s[i-1], d);
      last = (rec_k >= 0) && (i == rec_k + POST_N);
      send(d, (i == 100) || (i == PRE + 3) || last);
      if (hit) begin
        rec_k = i;
        chk("trig_pulse", int'(triggered), 1);
      end
      if (rec_k >= 0 && stop_post >= 0 && i == rec_k + stop_post) begin
        ok = 1; break;
      end
      if (last) begin ok = 1; break; end
      gap;
      if (rec_k < 0 && i > 4000) break;
    end
    chk("record_reached", int'(ok), 1);
    if (stop_post < 0 && ok) begin
      chk("trig_count", trig_seen - t0, 1);
      for (int j = 0; j < DEPTH; j++) pend[j] = rec_s[rec_k - PRE + j];
      repeat (3) tick;
      for (int j = 0; j < 5; j++) begin send(int'($urandom_range(0, 255)), 0); gap; end
      chk("done_no_swap_dv", int'(disp_valid), int'(dv_exp));
      chk("done_no_swap_frame", int'(frame_cnt), frame_exp);
    end
  endtask

  task automatic do_swap;
    int old;
    old = dv_exp ? exp_disp[PRE] : 0;
    rd_addr = PRE[AW-1:0];
    i_vs = 1;
    tick;
    i_vs = 0;
    chk("swap_early_dv", int'(disp_valid), int'(dv_exp));
    chk("swap_early_frame", int'(frame_cnt), frame_exp);
    tick;
    frame_exp = (frame_exp + 1) % 256;
    dv_exp = 1;
    exp_disp = pend;
    chk("swap_dv", int'(disp_valid), 1);
    chk("swap_frame", int'(frame_cnt), frame_exp);
    chk("swap_old_rd", int'(rd_data), old);
    tick;
    chk("swap_new_rd", int'(rd_data), exp_disp[PRE]);
  endtask

  task automatic check_disp(input int rec_id, input int nrand);
    int a;
    for (int v = 0; v < 8; v++) begin
      if (tbl[v].rec == rec_id) begin
        a = tbl[v].addr; rd_addr = a[AW-1:0];
        tick;
        chk("tbl_rd", int'(rd_data), tbl[v].exp);
      end
    end
    for (int n = 0; n < nrand + 4; n++) begin
      case (n)
        0: a = 0;
        1: a = PRE - 1;
        2: a = PRE;
        3: a = DEPTH - 1;
        default: a = int'($urandom_range(0, DEPTH - 1));
      endcase
      rd_addr = a[AW-1:0];
      tick;
      chk("rd_model", int'(rd_data), dv_exp ? exp_disp[a] : 0);
    end
  endtask

  initial begin
    int t0;
    tbl[0] = '{1, 512, 128}; tbl[1] = '{1, 511, 127};
    tbl[2] = '{1, 0, 128};   tbl[3] = '{1, 1023, 127};
    tbl[4] = '{2, 512, 100}; tbl[5] = '{2, 511, 101};
    tbl[6] = '{2, 513, 99};  tbl[7] = '{2, 1023, 101};

    #1 rst = 1;
    repeat (3) tick;
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_disp_valid", int'(disp_valid), 0);
    chk("rst_triggered", int'(triggered), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    rst = 0;
    tick;
    run = 1;
    tick; tick;

    // record 1: rising ramp
    run_record(0, 0, 128, -1);
    do_swap;
    check_disp(1, 32);

    // record 2: falling on descending ramp; display must hold record 1 meanwhile
    run_record(1, 1, 100, -1);
    check_disp(0, 8);
    do_swap;
    check_disp(2, 32);

    // abandon a record in POST, then capture a fresh one
    run_record(2, 1'($urandom_range(0, 1)), int'($urandom_range(30, 225)), 10);
    run = 0;
    tick;
    run = 1;
    tick; tick;
    chk("rundrop_dv", int'(disp_valid), 1);
    chk("rundrop_frame", int'(frame_cnt), frame_exp);
    check_disp(0, 16);
    run_record(2, 1'($urandom_range(0, 1)), int'($urandom_range(30, 225)), -1);
    do_swap;
    check_disp(0, 48);

    // asynchronous reset in the middle of POST
    run_record(2, 1'($urandom_range(0, 1)), int'($urandom_range(30, 225)), 5);
    rd_addr = PRE[AW-1:0];
    #2 rst = 1;
    #1;
    chk("arst_rd_data", int'(rd_data), 0);
    chk("arst_disp_valid", int'(disp_valid), 0);
    chk("arst_triggered", int'(triggered), 0);
    chk("arst_frame_cnt", int'(frame_cnt), 0);
    tick;
    rst = 0;
    dv_exp = 0; frame_exp = 0;
    tick; tick;

    // constant input below the level never triggers
    trig_edge = 0; trig_level = 128; t0 = trig_seen;
    for (int i = 0; i < 1500; i++) begin
      send(50, i == 700);
      gap;
    end
    chk("const_no_trig", trig_seen - t0, 0);
    chk("const_dv", int'(disp_valid), 0);
    chk("const_frame", int'(frame_cnt), 0);
    check_disp(0, 4);
    i_vs = 1; tick; i_vs = 0;
    repeat (4) tick;
    chk("const_vs_dv", int'(disp_valid), 0);
    chk("const_vs_frame", int'(frame_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
